// File: rtl/snow64_bfloat16_vector_fpu_if.sv
// snow64_bfloat16_vector_fpu_if
//   Command/result handshake bundle for the bfloat16 vector FPU.
//   Ports (signals):
//     in_valid/in_ready           command handshake
//     in_oper[2:0]                operation code
//     in_lane_mask[LANES]         per-lane enable
//     in_a/in_b[16*LANES]         operands, lane i at [16i+15:16i]
//     out_valid/out_ready         result handshake
//     out_data[16*LANES]          per-lane results
//     out_lane_mask[LANES]        mask of the command that produced out_data
//     busy                        FIFO non-empty or sequencer active
//   master: command source / result sink.  slave: the FPU.
interface snow64_bfloat16_vector_fpu_if #(
  parameter int LANES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_oper;
  logic [LANES-1:0]      in_lane_mask;
  logic [16*LANES-1:0]   in_a;
  logic [16*LANES-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*LANES-1:0]   out_data;
  logic [LANES-1:0]      out_lane_mask;
  logic                  busy;

  modport master (
    output in_valid, in_oper, in_lane_mask, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_lane_mask, busy
  );

  modport slave (
    input  in_valid, in_oper, in_lane_mask, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_lane_mask, busy
  );
endinterface

// File: rtl/snow64_bfloat16_vector_fpu.sv
// snow64_bfloat16_vector_fpu
//   LANES-wide bfloat16 vector unit. Commands are queued in a small FIFO,
//   issued one at a time to per-lane Add/Sub/Mul/Div units (Slt is a
//   combinational compare), and the gathered lane results are held until
//   the consumer takes them.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    snow64_bfloat16_vector_fpu_if.slave (command/result handshake)
//
//   state | meaning
//   IDLE  | nothing issued, waiting for a queued command
//   START | one-cycle unit start pulse for the issued command
//   WAIT  | collecting per-lane done flags
//   HOLD  | result presented on out_*, waiting for out_ready

package snow64_bf16_pkg;
  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_SLT       = 3'd2;
  localparam logic [2:0] OP_MUL       = 3'd3;
  localparam logic [2:0] OP_DIV       = 3'd4;
  localparam logic [2:0] OP_ADD_AGAIN = 3'd5;

  localparam int ADD_LAT = 2;
  localparam int SUB_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 5;

  // Arithmetic truncates, flushes subnormals to zero and saturates to inf.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [7:0]  d;
    logic [10:0] mx, my;
    logic [11:0] sum;
    logic [6:0]  mant;
    int          e;
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    mx = (x[14:7] == 8'd0) ? 11'd0 : {1'b1, x[6:0], 3'b000};
    my = (y[14:7] == 8'd0) ? 11'd0 : {1'b1, y[6:0], 3'b000};
    d  = x[14:7] - y[14:7];
    my = (d > 8'd10) ? 11'd0 : (my >> d);
    e  = int'(x[14:7]);
    if (x[15] == y[15]) begin
      sum = {1'b0, mx} + {1'b0, my};
    end else begin
      sum = {1'b0, mx - my};
      for (int i = 0; i < 11; i++) begin
        if (!sum[10] && sum != 12'd0) begin
          sum = sum << 1;
          e   = e - 1;
        end
      end
    end
    if (sum[11]) e = e + 1;
    mant = 7'(sum >> (sum[11] ? 4 : 3));
    if (sum == 12'd0 || e <= 0) r = 16'h0000;
    else if (e >= 255)          r = {x[15], 8'hFF, 7'h00};
    else                        r = {x[15], 8'(e), mant};
    return r;
  endfunction

  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p, r;
    logic [6:0]  mant;
    int          e;
    p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) e = e + 1;
    mant = 7'(p >> (p[15] ? 8 : 7));
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0 || e <= 0) r = 16'h0000;
    else if (e >= 255) r = {a[15] ^ b[15], 8'hFF, 7'h00};
    else               r = {a[15] ^ b[15], 8'(e), mant};
    return r;
  endfunction

  function automatic logic [15:0] bf16_div(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] q;
    logic [15:0] r;
    logic [6:0]  mant;
    int          e;
    // Quotient of the 1.7 mantissas scaled by 2^9 lands in [256,1024).
    q = {1'b1, a[6:0], 9'd0} / {9'd0, 1'b1, b[6:0]};
    e = int'(a[14:7]) - int'(b[14:7]) + 127;
    if (!q[9]) e = e - 1;
    mant = 7'(q >> (q[9] ? 2 : 1));
    if (a[14:7] == 8'd0)                      r = 16'h0000;
    else if (b[14:7] == 8'd0 || e >= 255)     r = {a[15] ^ b[15], 8'hFF, 7'h00};
    else if (e <= 0)                          r = 16'h0000;
    else                                      r = {a[15] ^ b[15], 8'(e), mant};
    return r;
  endfunction

  // Signed compare; both zeros (and subnormals) compare equal.
  function automatic logic bf16_lt(input logic [15:0] a, input logic [15:0] b);
    logic        sa, sb;
    logic [14:0] ma, mb;
    sa = (a[14:7] == 8'd0) ? 1'b0  : a[15];
    sb = (b[14:7] == 8'd0) ? 1'b0  : b[15];
    ma = (a[14:7] == 8'd0) ? 15'd0 : a[14:0];
    mb = (b[14:7] == 8'd0) ? 15'd0 : b[14:0];
    if (sa != sb) return sa;
    else if (!sa) return ma < mb;
    else          return ma > mb;
  endfunction
endpackage

// Fixed-latency lane unit: result registered on start, data_valid pulses
// LATENCY-1 edges after the start edge.
module snow64_bf16_unit
  import snow64_bf16_pkg::*;
#(
  parameter logic [2:0] OPER    = OP_ADD,
  parameter int         LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        data_valid,
  output logic [15:0] data
);
  localparam int CW = $clog2(LATENCY + 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [15:0]   result;

  always_comb begin
    result = 16'h0000;
    case (OPER)
      OP_ADD, OP_ADD_AGAIN: result = bf16_add(a, b);
      OP_SUB:               result = bf16_add(a, {~b[15], b[14:0]});
      OP_MUL:               result = bf16_mul(a, b);
      OP_DIV:               result = bf16_div(a, b);
      default:              result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      data    <= 16'h0000;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(LATENCY - 1);
      data    <= result;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign data_valid = running && (cnt == '0);
endmodule

module snow64_bfloat16_vector_fpu
  import snow64_bf16_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int CMD_FIFO_DEPTH = 2,
  parameter int DRAIN_CYCLES   = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  snow64_bfloat16_vector_fpu_if.slave bus
);
  localparam int W  = 16 * LANES;
  localparam int AW = $clog2(CMD_FIFO_DEPTH);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef struct packed {
    logic [2:0]       oper;
    logic [LANES-1:0] mask;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  cmd_t             fifo_mem [CMD_FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, push, pop;
  logic [DW-1:0]    drain_cnt;
  state_t           state, state_nx;
  cmd_t             issue;
  logic [LANES-1:0] done;
  logic [W-1:0]     result;
  logic             is_unit_op;
  logic             lane_dv   [LANES];
  logic [15:0]      lane_data [LANES];
  logic             lane_lt   [LANES];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.in_ready = !fifo_full && (drain_cnt == '0);
  assign push = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{bus.in_oper, bus.in_lane_mask, bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      drain_cnt <= DW'(DRAIN_CYCLES);
    end else begin
      if (push)             wr_ptr    <= wr_ptr + 1'b1;
      if (pop)              rd_ptr    <= rd_ptr + 1'b1;
      if (drain_cnt != '0)  drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) begin
        state_nx = START;
        pop      = 1'b1;
      end
      START: state_nx = WAIT;
      WAIT:  if (&done) state_nx = HOLD;
      HOLD:  if (bus.out_ready) begin
        if (!fifo_empty) begin
          state_nx = START;
          pop      = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue <= '0;
    else if (pop) issue <= fifo_mem[rd_ptr[AW-1:0]];
  end

  assign is_unit_op = (issue.oper == OP_ADD) || (issue.oper == OP_SUB) ||
                      (issue.oper == OP_MUL) || (issue.oper == OP_DIV) ||
                      (issue.oper == OP_ADD_AGAIN);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [15:0] a_i, b_i;
    logic        go;
    logic        dv_add, dv_sub, dv_mul, dv_div;
    logic [15:0] d_add, d_sub, d_mul, d_div;

    assign a_i = issue.a[16*i +: 16];
    assign b_i = issue.b[16*i +: 16];
    assign go  = (state == START) && issue.mask[i];

    snow64_bf16_unit #(.OPER(OP_ADD), .LATENCY(ADD_LAT)) u_add (
      .clk(clk), .rst_n(rst_n),
      .start(go && (issue.oper == OP_ADD || issue.oper == OP_ADD_AGAIN)),
      .a(a_i), .b(b_i), .data_valid(dv_add), .data(d_add));
    snow64_bf16_unit #(.OPER(OP_SUB), .LATENCY(SUB_LAT)) u_sub (
      .clk(clk), .rst_n(rst_n), .start(go && issue.oper == OP_SUB),
      .a(a_i), .b(b_i), .data_valid(dv_sub), .data(d_sub));
    snow64_bf16_unit #(.OPER(OP_MUL), .LATENCY(MUL_LAT)) u_mul (
      .clk(clk), .rst_n(rst_n), .start(go && issue.oper == OP_MUL),
      .a(a_i), .b(b_i), .data_valid(dv_mul), .data(d_mul));
    snow64_bf16_unit #(.OPER(OP_DIV), .LATENCY(DIV_LAT)) u_div (
      .clk(clk), .rst_n(rst_n), .start(go && issue.oper == OP_DIV),
      .a(a_i), .b(b_i), .data_valid(dv_div), .data(d_div));

    assign lane_lt[i] = bf16_lt(a_i, b_i);

    // Only the unit that belongs to the issued oper can complete a lane.
    always_comb begin
      lane_dv[i]   = 1'b0;
      lane_data[i] = 16'h0000;
      case (issue.oper)
        OP_ADD, OP_ADD_AGAIN: begin lane_dv[i] = dv_add; lane_data[i] = d_add; end
        OP_SUB:               begin lane_dv[i] = dv_sub; lane_data[i] = d_sub; end
        OP_MUL:               begin lane_dv[i] = dv_mul; lane_data[i] = d_mul; end
        OP_DIV:               begin lane_dv[i] = dv_div; lane_data[i] = d_div; end
        default:              begin lane_dv[i] = 1'b0;   lane_data[i] = 16'h0000; end
      endcase
    end
  end

  // Lanes with no unit to wait on complete at START exit; the rest on their
  // unit's data_valid in WAIT. A lane already done ignores further pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= '0;
      result <= '0;
    end else begin
      case (state)
        START: for (int i = 0; i < LANES; i++) begin
          if (!issue.mask[i] || !is_unit_op) begin
            done[i]           <= 1'b1;
            result[16*i +: 16] <= (issue.mask[i] && issue.oper == OP_SLT) ?
                                  {15'd0, lane_lt[i]} : 16'h0000;
          end
        end
        WAIT: for (int i = 0; i < LANES; i++) begin
          if (!done[i] && lane_dv[i]) begin
            done[i]           <= 1'b1;
            result[16*i +: 16] <= lane_data[i];
          end
        end
        HOLD: if (bus.out_ready) done <= '0;
        default: ;
      endcase
    end
  end

  assign bus.out_valid     = (state == HOLD);
  assign bus.out_data      = result;
  assign bus.out_lane_mask = issue.mask;
  assign bus.busy          = !fifo_empty || (state != IDLE);
endmodule

// File: tb/tb_snow64_bfloat16_vector_fpu.sv
// tb_snow64_bfloat16_vector_fpu
//   Scoreboard bench: expected results are queued as commands are accepted
//   and compared when the FPU hands a result over.
module tb_snow64_bfloat16_vector_fpu;
  localparam int LANES = 4;
  localparam int W     = 16 * LANES;
  localparam int DEPTH = 2;
  localparam int DRAIN = 16;

  localparam logic [15:0] ONE   = 16'h3F80;
  localparam logic [15:0] NEG1  = 16'hBF80;
  localparam logic [15:0] TWO   = 16'h4000;
  localparam logic [15:0] THREE = 16'h4040;
  localparam logic [15:0] SIX   = 16'h40C0;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [LANES-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow64_bfloat16_vector_fpu_if #(.LANES(LANES)) bus ();

  snow64_bfloat16_vector_fpu #(
    .LANES(LANES), .CMD_FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", W'(sb.size() != 0), W'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_mask", W'(bus.out_lane_mask), W'(e.mask));
      end
    end
  end

  task automatic drive_cmd(input logic [2:0] op, input logic [LANES-1:0] mask,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_oper      = op;
    bus.in_lane_mask = mask;
    bus.in_a         = a;
    bus.in_b         = b;
    bus.in_valid     = 1'b1;
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic [LANES-1:0] mask,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_data);
    int n = 0;
    drive_cmd(op, mask, a, b);
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
    check({tag, "_accept"}, W'(bus.in_ready), W'(1));
    if (bus.in_ready) sb.push_back('{data: exp_data, mask: mask});
    @(posedge clk); #2;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_lat"}, W'(cyc - acc_cyc), W'(exp_lat));
    @(posedge clk); #2;
  endtask

  task automatic check_drain(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check(tag, W'(n), W'(DRAIN));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 300) begin @(negedge clk); n++; end
    check(tag, W'(bus.busy), W'(0));
  endtask

  logic [2:0]   bp_op [4];
  logic [W-1:0] bp_a  [4];
  logic [W-1:0] bp_b  [4];
  logic [W-1:0] bp_e  [4];

  initial begin
    int n_acc;
    int n;
    bus.in_valid = 1'b0; bus.in_oper = 3'd0; bus.in_lane_mask = '0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_mask", W'(bus.out_lane_mask), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_in_ready", W'(bus.in_ready), W'(0));
    rst_n = 1'b1;
    check_drain("drain_init");

    send("slt", 3'd2, 4'b0101, rep(NEG1), rep(ONE), 64'h0000_0001_0000_0001);
    wait_out("slt", 3);
    send("add", 3'd0, 4'hF, rep(ONE), rep(ONE), rep(TWO));
    wait_out("add", 3 + 2);
    send("sub", 3'd1, 4'b0011, rep(TWO), rep(ONE), 64'h0000_0000_3F80_3F80);
    wait_out("sub", 3 + 2);
    send("mul", 3'd3, 4'hF, rep(TWO), rep(THREE), rep(SIX));
    wait_out("mul", 3 + 3);
    send("div", 3'd4, 4'hF, rep(SIX), rep(TWO), rep(THREE));
    wait_out("div", 3 + 5);
    send("addagain", 3'd5, 4'hF, {ONE, ONE, TWO, ONE}, {NEG1, ONE, ONE, ONE},
         64'h0000_4000_4040_4000);
    wait_out("addagain", 3 + 2);
    send("rsvd", 3'd7, 4'hF, rep(ONE), rep(ONE), '0);
    wait_out("rsvd", 3);
    send("nomask", 3'd0, 4'h0, rep(ONE), rep(ONE), '0);
    wait_out("nomask", 3);

    // Backpressure: fill the FIFO behind a held result.
    bp_op[0] = 3'd0; bp_a[0] = rep(ONE); bp_b[0] = rep(ONE);   bp_e[0] = rep(TWO);
    bp_op[1] = 3'd3; bp_a[1] = rep(TWO); bp_b[1] = rep(THREE); bp_e[1] = rep(SIX);
    bp_op[2] = 3'd4; bp_a[2] = rep(SIX); bp_b[2] = rep(TWO);   bp_e[2] = rep(THREE);
    bp_op[3] = 3'd1; bp_a[3] = rep(TWO); bp_b[3] = rep(ONE);   bp_e[3] = rep(ONE);
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cmd(bp_op[k], 4'hF, bp_a[k], bp_b[k]);
      @(negedge clk);
      if (!bus.in_ready) break;
      sb.push_back('{data: bp_e[k], mask: 4'hF});
      n_acc++;
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    check("bp_queued", W'(n_acc - 1), W'(DEPTH));
    n = 0;
    while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
    check("bp_first", bus.out_data, rep(TWO));
    repeat (8) @(negedge clk);
    check("bp_hold", bus.out_data, rep(TWO));
    check("bp_hold_valid", W'(bus.out_valid), W'(1));
    check("bp_full", W'(bus.in_ready), W'(0));
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    wait_idle("bp_drain");
    check("bp_sb_empty", W'(sb.size()), W'(0));

    // Reset while a Mul is in flight.
    @(posedge clk); #2;
    send("mulrst", 3'd3, 4'hF, rep(TWO), rep(THREE), rep(SIX));
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", W'(bus.out_valid), W'(0));
    check("mrst_out_data", bus.out_data, '0);
    check("mrst_out_mask", W'(bus.out_lane_mask), W'(0));
    check("mrst_busy", W'(bus.busy), W'(0));
    check("mrst_in_ready", W'(bus.in_ready), W'(0));
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_drain("drain_mid");
    send("divrst", 3'd4, 4'hF, rep(TWO), rep(TWO), rep(ONE));
    wait_out("divrst", 3 + 5);

    wait_idle("final_idle");
    check("final_sb_empty", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snow64_bfloat16_vector_fpu.md
SNOW64_BFLOAT16_VECTOR_FPU -- requirements
Module: snow64_bfloat16_vector_fpu

Interface
REQ-001 SHALL have parameter LANES, default 4, number of bfloat16 lanes (1..8).
REQ-002 SHALL have parameter CMD_FIFO_DEPTH, default 2, command FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 16, post-reset cycles during which commands are refused.
REQ-004 SHALL have clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have in_valid  in  1  command offered.
REQ-007 SHALL have in_ready  out  1  command accepted on an edge where in_valid && in_ready.
REQ-008 SHALL have in_oper  in  3  0 Add, 1 Sub, 2 Slt, 3 Mul, 4 Div, 5 AddAgain, 6-7 reserved.
REQ-009 SHALL have in_lane_mask  in  LANES  per-lane enable.
REQ-010 SHALL have in_a, in_b  in  16*LANES  operands, lane i at bits [16i+15:16i].
REQ-011 SHALL have out_valid  out  1  result available.
REQ-012 SHALL have out_ready  in  1  result consumed on an edge where out_valid && out_ready.
REQ-013 SHALL have out_data  out  16*LANES  per-lane results.
REQ-014 SHALL have out_lane_mask  out  LANES  mask of the command that produced out_data.
REQ-015 SHALL have busy  out  1  high when FIFO non-empty or state != IDLE.

Function
REQ-016 SHALL instantiate per lane the team's existing bfloat16 Add, Sub, Slt, Mul and Div units; AddAgain SHALL use the Add unit.
REQ-017 SHALL buffer accepted commands in a CMD_FIFO_DEPTH FIFO; in_ready = !full && drain counter expired; no same-edge push bypass when full.
REQ-018 Sequencer states: IDLE, START, WAIT, HOLD.
REQ-019 IDLE -> START when FIFO non-empty; at that edge the FIFO head SHALL be copied into an issue register and popped.
REQ-020 START lasts exactly one cycle: unit start asserted only for the selected unit of lanes enabled in the issue mask; operands driven from the issue register, held stable through WAIT.
REQ-021 Per-lane sticky done flags: set at START exit for masked-off lanes, for Slt and for reserved opers; otherwise set by the lane unit's data_valid while in WAIT.
REQ-022 Lane result captured when its done flag sets: unit data; Slt result zero-extended to 16 bits (bit 0 = a<b); masked-off and reserved lanes = 16'h0000.
REQ-023 WAIT -> HOLD on the edge where all done flags are set; out_valid asserts in HOLD, out_data/out_lane_mask stable until handshake.
REQ-024 HOLD -> START if FIFO non-empty at the handshake edge, else IDLE; done flags cleared on leaving HOLD.
REQ-025 Latency: out_valid exactly 3 edges after acceptance into an empty idle block for Slt, reserved oper or all-zero mask; 3 + max unit latency otherwise.
REQ-026 Unit data_valid outside WAIT or for a lane not started SHALL be ignored.
REQ-027 Command accepted during HOLD or WAIT SHALL queue without disturbing in-flight result.

Reset
REQ-028 On rst_n low: state IDLE, FIFO empty, done flags clear, out_valid 0, out_data 0, out_lane_mask 0, busy 0, in_ready 0, drain counter loaded with DRAIN_CYCLES.
REQ-029 After rst_n release, in_ready SHALL rise exactly DRAIN_CYCLES edges later; reset mid-operation SHALL discard in-flight and queued commands.

Verification
REQ-030 Slt, LANES=4, mask 4'b0101, a lanes = 16'hBF80 (-1.0), b = 16'h3F80 (1.0) -> out_valid 3 edges after accept, out_data lanes 0,2 = 16'h0001, lanes 1,3 = 0.
REQ-031 Add 16'h3F80+16'h3F80 all lanes -> every lane 16'h4000; out_lane_mask 4'hF.
REQ-032 out_ready held low, push commands until in_ready drops -> exactly CMD_FIFO_DEPTH queued, first result held unchanged; release -> results returned in order.
REQ-033 Mul issued, rst_n pulsed low in WAIT -> outputs zero immediately, in_ready low for 16 cycles, next Div 16'h4000/16'h4000 returns 16'h3F80.
REQ-034 in_oper=7, mask 4'hF -> out_valid after 3 edges, out_data all zero.
